fpu_fp64_conv_arbiter: RTL
==========================

// Module: fpu_fp64_conv_arbiter
// PURPOSE
//  Shares one FP64->FP80 load converter (enable/done, registered result) among
//  NUM_REQ requesters (e.g. microcode operand fetch, FLD m64 path).
//  Round-robin arbitration, captures operand + tag, pulses converter enable once,
//  waits for done under a watchdog, returns the 80-bit result via valid/ready.
// PARAMETERS
//  NUM_REQ          2   number of requesters (>=2)
//  TAG_W            3   opaque tag width carried request->response
//  WATCHDOG_CYCLES  15  max cycles in WAIT before timeout (>=2)
// PORTS
//  clk          in   1              clock
//  reset_n      in   1              asynchronous reset, active-low
//  req_valid    in   NUM_REQ        per-requester request valid
//  req_ready    out  NUM_REQ        one-hot accept (combinational from state + grant)
//  req_data     in   NUM_REQ*64     FP64 operands, requester i at [64*i +: 64]
//  req_tag      in   NUM_REQ*TAG_W  tags, requester i at [TAG_W*i +: TAG_W]
//  conv_enable  out  1              converter start, exactly one cycle per op
//  conv_fp64    out  64             converter operand (registered, stable ISSUE..WAIT)
//  conv_fp80    in   80             converter result, valid when conv_done=1
//  conv_done    in   1              converter completion
//  rsp_valid    out  1              response valid
//  rsp_ready    in   1              response consumer ready
//  rsp_data     out  80             FP80 result
//  rsp_tag      out  TAG_W          tag of the originating request
//  rsp_grant    out  NUM_REQ        one-hot id of the originating requester
//  busy         out  1              state != IDLE
//  timeout_err  out  1              one-cycle pulse on watchdog expiry
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE, RR pointer 0, every output and register 0.
//  FSM IDLE -> ISSUE -> WAIT -> HOLD -> (IDLE | ISSUE).
//  - IDLE: if any req_valid, the RR winner gets req_ready=1 this cycle; latch
//    data/tag/grant, pointer := winner+1 (mod NUM_REQ), -> ISSUE. Otherwise stay.
//  - ISSUE: conv_enable=1 for this cycle only; clear watchdog; -> WAIT.
//  - WAIT: conv_done=1 -> latch conv_fp80 into rsp_data, -> HOLD.
//    Otherwise count; count==WATCHDOG_CYCLES-1 without done -> timeout_err=1 for
//    one cycle, no response, -> IDLE. Done wins if it arrives on the expiry cycle.
//  - HOLD: rsp_valid=1; rsp_data/tag/grant stable until rsp_ready.
//    rsp_ready=1 and any req_valid -> accept the RR winner this same cycle
//    (req_ready=1), -> ISSUE. rsp_ready=1 and no request -> IDLE.
//  Latency with 1-cycle converter: accept at A, conv_enable at A+1, done at A+2,
//  rsp_valid at A+3. Back-to-back throughput: 1 op / 3 cycles.
//  conv_done outside WAIT is ignored. req_valid may drop before accept; no
//  request is granted unless valid in the accept cycle.
//  Arbitration: scan from pointer upward with wrap. The pointer updates only
//  on an accept.
//  Watchdog counter width $clog2(WATCHDOG_CYCLES+1). Saturates, never wraps.
//  Reset mid-op: in-flight op and response are dropped. A stale conv_done after
//  release is ignored (state IDLE).
// STRUCTURE
//  Package fpu_conv_pkg: state enum (S_IDLE,S_ISSUE,S_WAIT,S_HOLD),
//  FP64_W=64, FP80_W=80 localparams.
//  Sub-module fpu_rr_arbiter: NUM_REQ req vector + pointer -> one-hot grant
//  (combinational). This FSM owns the pointer register.
// TESTING (converter model: 1-cycle registered done unless stated)
//  1. req0 data 64'h3FF0000000000000 tag 5 -> conv_enable at A+1 with that
//     operand; rsp_valid at A+3, rsp_data 80'h3FFF8000000000000000, tag 5, grant 01.
//  2. req0 and req1 both held valid, rsp_ready=1 -> grants 01,10,01,10 over
//     4 ops, 3 cycles apart.
//  3. rsp_ready=0 for 10 cycles in HOLD -> rsp_* stable, req_ready=0, no conv_enable.
//  4. Model never asserts done, WATCHDOG_CYCLES=15 -> timeout_err one pulse,
//     rsp_valid stays 0, back to IDLE; the next req completes normally.
//  5. Model asserts done at the cycle before expiry -> response delivered,
//     no timeout_err.
//  6. reset_n=0 during WAIT -> all outputs 0 immediately; conv_done after
//     release -> no rsp_valid.

Source files
------------

// File: rtl/fpu_conv_pkg.sv
// Purpose: shared types and widths for the FP64->FP80 converter arbiter.
// Latency: n/a (package only).
// Backpressure: n/a.
package fpu_conv_pkg;

    localparam int FP64_W = 64;
    localparam int FP80_W = 80;

    // Per-operation flow: grant a requester, fire the converter, wait for it,
    // then hold the result until the consumer takes it.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/fpu_rr_arbiter.sv
// Purpose: round-robin one-hot grant, scanning upward from ptr with wrap.
// Latency: combinational.
// Backpressure: none; the caller decides whether the grant is used.
// Ports: req (request vector), ptr (highest-priority index), grant (one-hot or 0).
module fpu_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic found;

    // Outer loop walks priority order (ptr, ptr+1, ...); the inner loop maps
    // that rotated position back to a physical requester with constant indices.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req[j] && (((int'(ptr) + i) % NUM_REQ) == j)) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fpu_fp64_conv_arbiter.sv
// Purpose: shares one FP64->FP80 converter among NUM_REQ requesters (round-robin).
// Latency: accept A, conv_enable A+1, rsp_valid one cycle after conv_done (A+3 best case).
// Backpressure: rsp_ready=0 holds the response and blocks new accepts; watchdog aborts a hung converter.
// Ports: req_valid/req_ready/req_data/req_tag (requesters), conv_enable/conv_fp64/
//        conv_fp80/conv_done (converter), rsp_valid/rsp_ready/rsp_data/rsp_tag/
//        rsp_grant (response), busy, timeout_err (one-cycle watchdog pulse).
module fpu_fp64_conv_arbiter
    import fpu_conv_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int TAG_W           = 3,
    parameter int WATCHDOG_CYCLES = 15
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*FP64_W-1:0]  req_data,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic                       conv_enable,
    output logic [FP64_W-1:0]          conv_fp64,
    input  logic [FP80_W-1:0]          conv_fp80,
    input  logic                       conv_done,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [FP80_W-1:0]          rsp_data,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic [NUM_REQ-1:0]         rsp_grant,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(WATCHDOG_CYCLES + 1);

    state_t               state;
    logic [PTR_W-1:0]     ptr;
    logic [WD_W-1:0]      wd_cnt;
    logic [NUM_REQ-1:0]   grant;
    logic                 accept;
    logic [FP64_W-1:0]    sel_data;
    logic [TAG_W-1:0]     sel_tag;
    logic [PTR_W-1:0]     next_ptr;

    fpu_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // Accept windows: idle, or the cycle the held response drains. Gated by
    // reset_n so req_ready is 0 while reset is asserted.
    assign accept = reset_n && (|req_valid) &&
                    ((state == S_IDLE) || ((state == S_HOLD) && rsp_ready));

    assign req_ready   = {NUM_REQ{accept}} & grant;
    assign conv_enable = (state == S_ISSUE);
    assign rsp_valid   = (state == S_HOLD);
    assign busy        = (state != S_IDLE);

    // Operand/tag mux and the pointer value following the winner.
    always_comb begin
        sel_data = '0;
        sel_tag  = '0;
        next_ptr = ptr;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant[j]) begin
                sel_data = req_data[FP64_W*j +: FP64_W];
                sel_tag  = req_tag[TAG_W*j +: TAG_W];
                next_ptr = PTR_W'((j + 1) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            ptr         <= '0;
            wd_cnt      <= '0;
            conv_fp64   <= '0;
            rsp_data    <= '0;
            rsp_tag     <= '0;
            rsp_grant   <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;

            // Tag/grant change only on accept, which in HOLD coincides with the
            // response handshake, so they are stable while rsp_valid is high.
            if (accept) begin
                conv_fp64 <= sel_data;
                rsp_tag   <= sel_tag;
                rsp_grant <= grant;
                ptr       <= next_ptr;
            end

            case (state)
                S_IDLE: begin
                    if (accept) state <= S_ISSUE;
                end
                S_ISSUE: begin
                    wd_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    // Done is checked first so it wins on the expiry cycle.
                    if (conv_done) begin
                        rsp_data <= conv_fp80;
                        state    <= S_HOLD;
                    end else if (wd_cnt == WD_W'(WATCHDOG_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else if (wd_cnt != '1) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (rsp_ready) state <= accept ? S_ISSUE : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
